// File: rtl/motor_pkg.sv
// Shared definitions for the motor pin owner: mode codes, mux states and the
// idle pad drive of each protocol.
package motor_pkg;

    localparam logic [1:0] MODE_DSHOT  = 2'b00;
    localparam logic [1:0] MODE_SERIAL = 2'b01;
    localparam logic [1:0] MODE_OFF    = 2'b10;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_GUARD  = 2'd2
    } mux_state_e;

    typedef struct packed {
        logic out;
        logic oe;
    } pad_drive_t;

    // Level a protocol expects on an idle line; 10 and 11 both mean released.
    function automatic pad_drive_t idle_drive(input logic [1:0] mode);
        pad_drive_t d;
        d.out = 1'b0;
        d.oe  = 1'b0;
        if (mode == MODE_DSHOT) begin
            d.oe = 1'b1;
        end else if (mode == MODE_SERIAL) begin
            d.out = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/motor_pin_mux_sync_2ff.sv
// Two-flop synchroniser for an asynchronous input, with a selectable reset level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= RST_VAL;
            o_q  <= RST_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/motor_pin_mux.sv
// Hands one bidirectional motor pin between the DSHOT and serial engines, letting
// the outgoing engine finish and holding the incoming idle level before enabling.
module motor_pin_mux
    import motor_pkg::*;
#(
    parameter int GUARD_CYCLES  = 1024,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_mode,
    input  logic       i_dshot_out,
    input  logic       i_dshot_busy,
    input  logic       i_ser_tx,
    input  logic       i_ser_oe,
    input  logic       i_ser_busy,
    input  logic       i_pin_in,
    output logic       o_pin_out,
    output logic       o_pin_oe,
    output logic       o_ser_rx,
    output logic       o_dshot_en,
    output logic       o_ser_en,
    output logic [1:0] o_active_mode,
    output logic       o_switching
);

    localparam int CNT_MAX = (GUARD_CYCLES > DRAIN_TIMEOUT) ? GUARD_CYCLES : DRAIN_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    mux_state_e       state_q, state_d;
    logic [1:0]       active_q, active_d;
    logic [1:0]       target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_busy;
    pad_drive_t       pad_d, pad_q;
    logic             dshot_en_q, ser_en_q, switching_q;
    logic             rx_sync;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_pin_in),
        .o_q     (rx_sync)
    );

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        // An OFF owner has no engine, so it never holds the pin in DRAIN.
        if (active_q == MODE_DSHOT) begin
            out_busy = i_dshot_busy;
        end else if (active_q == MODE_SERIAL) begin
            out_busy = i_ser_busy;
        end else begin
            out_busy = 1'b0;
        end
        case (state_q)
            ST_ACTIVE: begin
                if (i_mode != active_q) begin
                    target_d = i_mode;
                    cnt_d    = '0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                target_d = i_mode;
                if (!out_busy || cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_GUARD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GUARD: begin
                // A new request mid-guard restarts the full idle interval.
                if (i_mode != target_q) begin
                    target_d = i_mode;
                    cnt_d    = '0;
                end else if (cnt_q == GUARD_LAST) begin
                    active_d = target_q;
                    state_d  = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_GUARD;
            end
        endcase
    end

    // DRAIN keeps the outgoing engine on the pad so it can finish its frame.
    always_comb begin
        pad_d.out = 1'b0;
        pad_d.oe  = 1'b0;
        if (state_q == ST_GUARD) begin
            pad_d = idle_drive(target_q);
        end else if (active_q == MODE_DSHOT) begin
            pad_d.out = i_dshot_out;
            pad_d.oe  = 1'b1;
        end else if (active_q == MODE_SERIAL) begin
            pad_d.out = i_ser_tx;
            pad_d.oe  = i_ser_oe;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_GUARD;
            active_q    <= MODE_DSHOT;
            target_q    <= MODE_DSHOT;
            cnt_q       <= '0;
            pad_q.out   <= 1'b0;
            pad_q.oe    <= 1'b1;
            dshot_en_q  <= 1'b0;
            ser_en_q    <= 1'b0;
            switching_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            pad_q       <= pad_d;
            dshot_en_q  <= (state_d == ST_ACTIVE) && (active_d == MODE_DSHOT);
            ser_en_q    <= (state_d == ST_ACTIVE) && (active_d == MODE_SERIAL);
            switching_q <= (state_d != ST_ACTIVE);
        end
    end

    assign o_pin_out     = pad_q.out;
    assign o_pin_oe      = pad_q.oe;
    assign o_dshot_en    = dshot_en_q;
    assign o_ser_en      = ser_en_q;
    assign o_active_mode = active_q;
    assign o_switching   = switching_q;
    assign o_ser_rx      = (state_q != ST_GUARD && active_q == MODE_SERIAL) ? rx_sync : 1'b1;

endmodule

// File: doc/motor_pin_mux.md
# motor_pin_mux

Owns one bidirectional motor/ESC pin and hands it between protocol engines according to the 2-bit mode driven by the mode register. Mode changes are applied safely: the outgoing engine finishes its current frame (bounded by a timeout), the pin is then held at the incoming protocol's idle level for a guard interval, and only then is the new engine enabled. It sits between the mode register and the DSHOT and one-wire serial (ESC passthrough) engines on one side, and the pad on the other.

## Interface
- `GUARD_CYCLES`, 1024: cycles the pin is held idle before a new engine is enabled; must be at least 1.
- `DRAIN_TIMEOUT`, 4096: maximum cycles spent waiting for the outgoing engine's busy flag to drop.
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_mode`  in  2  requested mode: 00 DSHOT, 01 SERIAL, 10/11 OFF.
- `i_dshot_out`  in  1  DSHOT engine pin level.
- `i_dshot_busy`  in  1  DSHOT frame in progress.
- `i_ser_tx`  in  1  serial engine transmit level.
- `i_ser_oe`  in  1  serial engine drive enable (half-duplex).
- `i_ser_busy`  in  1  serial byte in progress.
- `i_pin_in`  in  1  asynchronous pad input.
- `o_pin_out`  out  1  pad output level.
- `o_pin_oe`  out  1  pad output enable.
- `o_ser_rx`  out  1  synchronised pad input to the serial engine.
- `o_dshot_en`  out  1  DSHOT engine enable.
- `o_ser_en`  out  1  serial engine enable.
- `o_active_mode`  out  2  mode currently owning the pin.
- `o_switching`  out  1  high whenever the state is not ACTIVE.

## Operation
- **State machine:** ACTIVE, DRAIN, GUARD. Internal registers: `active_mode`, `target_mode`, `cnt`.
- **ACTIVE**
  - Pin source follows `active_mode`:
    - DSHOT: out = `i_dshot_out`, oe = 1.
    - SERIAL: out = `i_ser_tx`, oe = `i_ser_oe`.
    - OFF: out = 0, oe = 0.
  - The engine matching `active_mode` has its enable high; all other enables are low.
  - When `i_mode` differs from `active_mode`: `target_mode` takes `i_mode`, `cnt` is cleared, go to DRAIN. All enables drop on entry.
- **DRAIN**
  - The pin stays sourced from the outgoing `active_mode`, so the engine can finish its frame with its enable low.
  - `target_mode` tracks `i_mode` every cycle.
  - Exit to GUARD (with `cnt` cleared) when either:
    - the outgoing engine's busy flag is low (OFF counts as never busy), or
    - `cnt` reaches DRAIN_TIMEOUT−1.
  - Otherwise `cnt` increments.
- **GUARD**
  - The pin is driven to the idle level of `target_mode`:
    - DSHOT: out 0, oe 1.
    - SERIAL: out 1, oe 0 (line pulled up externally).
    - OFF: out 0, oe 0.
  - If `i_mode` differs from `target_mode`: `target_mode` takes `i_mode` and `cnt` is cleared (the guard restarts).
  - Else, when `cnt` reaches GUARD_CYCLES−1: `active_mode` takes `target_mode`, go to ACTIVE.
  - Else `cnt` increments.
- **No shortcut:** a request that returns to the old mode during DRAIN or GUARD still completes both DRAIN and GUARD.
- **Receive path:**
  - `i_pin_in` passes through a 2-flop synchroniser.
  - `o_ser_rx` = synchronised value while `active_mode` is SERIAL and the state is ACTIVE or DRAIN; otherwise it is forced to 1.
- **Counter width:** `cnt` is `$clog2(max(GUARD_CYCLES, DRAIN_TIMEOUT))` bits, and never wraps.
- **Reset values:** state GUARD, `active_mode` = `target_mode` = 00, `cnt` = 0.
  - `o_pin_out` 0, `o_pin_oe` 1.
  - `o_ser_rx` 1, both synchroniser flops 1.
  - `o_dshot_en` 0, `o_ser_en` 0.
  - `o_active_mode` 00, `o_switching` 1.
  - The first DSHOT enable therefore arrives only after a full guard.

## Timing
- `o_pin_out` and `o_pin_oe` are registered: 1-cycle latency from the engine inputs, or from the state change, to the pad.
- The enables, `o_active_mode` and `o_switching` are registered, and update in the cycle after the state transition is decided.
- `o_ser_rx` has a 2-cycle latency from `i_pin_in`.
- A change on `i_mode` is sampled on the next rising edge; DRAIN begins on that edge.
- Minimum switch time with an idle engine is 1 (DRAIN) + GUARD_CYCLES cycles, after which the new enable is high.
- Reset asserted mid-switch returns immediately to the reset values. The DSHOT idle drive (oe 1, out 0) is asynchronous with reset.

## Structure
- **Shared package `motor_pkg`:**
  - `MODE_DSHOT` = 2'b00, `MODE_SERIAL` = 2'b01, `MODE_OFF` = 2'b10.
  - State encoding `ST_ACTIVE`, `ST_DRAIN`, `ST_GUARD`.
  - Consumed by the mode register and the engines as well as this block.
- **Sub-module `sync_2ff`:** 2-flop synchroniser with asynchronous active-low reset and a reset-value parameter (here 1).

## Test plan
All scenarios use GUARD_CYCLES=16 and DRAIN_TIMEOUT=32.
- **Reset release with `i_mode`=00:** `o_pin_oe`=1 and `o_pin_out`=0 throughout; `o_dshot_en` rises exactly 16 cycles after release; `o_switching` then falls.
- **Switch 00→01 while `i_dshot_busy`=1 for 10 more cycles:**
  - The pin follows `i_dshot_out` for those 10 cycles.
  - Then 16 cycles of oe=0, out=1.
  - Then `o_ser_en`=1 and `o_active_mode`=01.
- **Switch 00→01 with `i_dshot_busy` stuck at 1:** DRAIN ends after exactly 32 cycles, followed by the 16-cycle guard.
- **`i_mode` 00→01, then 01→10 at guard cycle 8:** the guard restarts and the pin ends at oe=0 after a further 16 cycles; no enable asserts; `o_active_mode`=10.
- **SERIAL active, toggle `i_pin_in`:** `o_ser_rx` follows with a 2-cycle lag. After a switch to 00, `o_ser_rx` is held at 1.
- **Assert `i_rst_n` low at guard cycle 5 of a 00→01 switch:**
  - The same cycle shows oe=1, out=0, both enables 0.
  - After release, a full 16-cycle guard precedes `o_dshot_en`.
